// File: rtl/eth_speed_detect_pkg.sv
// Shared types for the RGMII link-speed detector: speed encoding and the
// mii_select derivation used by the MAC/PHY wrappers.
package eth_speed_pkg;

  typedef enum logic [1:0] {
    SPEED_10M   = 2'b00,
    SPEED_100M  = 2'b01,
    SPEED_1000M = 2'b10
  } speed_t;

  // Only gigabit runs GMII; every other speed selects the MII path.
  localparam speed_t GMII_SPEED = SPEED_1000M;

  function automatic logic mii_sel(speed_t s);
    return s != GMII_SPEED;
  endfunction

endpackage

// File: rtl/eth_speed_detect_if.sv
// Status bundle from the speed detector to the MAC and PHY interface logic.
interface eth_speed_detect_if #(
  parameter int REF_CNT_W = 7
);
  import eth_speed_pkg::*;

  speed_t               speed;
  logic                 mii_select;
  logic                 speed_change;
  logic                 rx_clk_lost;
  logic [REF_CNT_W-1:0] measure_count;

  modport master (output speed, mii_select, speed_change, rx_clk_lost, measure_count);
  modport slave  (input  speed, mii_select, speed_change, rx_clk_lost, measure_count);

endinterface

// File: rtl/eth_bit_sync.sv
// N-stage single-bit synchronizer, async active-low reset to 0.
module eth_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= (ff << 1) | STAGES'(d);
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/eth_speed_detect.sv
// RGMII link-speed detector: windows the rate of the rx-domain prescaler toggle
// against clk, classifies 10/100/1000M with confirmation, flags RX clock loss.
// Define ETH_SPEED_FORCE_EN to add the force_en/force_speed override ports.
module eth_speed_detect
  import eth_speed_pkg::*;
#(
  parameter int         SYNC_STAGES  = 3,
  parameter int         REF_CNT_W    = 7,
  parameter int         EDGE_CNT_W   = 2,
  parameter int         THRESH_100M  = 32,
  parameter int         CONFIRM      = 1,
  parameter int         LOSS_WINDOWS = 4,
  parameter logic [1:0] RESET_SPEED  = 2'b10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_toggle,
`ifdef ETH_SPEED_FORCE_EN
  input  logic       force_en,
  input  logic [1:0] force_speed,
`endif
  eth_speed_detect_if.master stat
);

  localparam int CNF_W  = $clog2(CONFIRM + 1);
  localparam int LOST_W = $clog2(LOSS_WINDOWS + 1);

  // The sub-synchronizer supplies all but the last stage; the last stage lives
  // here so both of the final two stages are visible for edge detection.
  logic sync_q, sync_d, edge_det;

  eth_bit_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_toggle),
    .q     (sync_q)
  );

  assign edge_det = sync_q ^ sync_d;

  logic [REF_CNT_W-1:0]  ref_cnt;
  logic [EDGE_CNT_W-1:0] edge_cnt;
  logic [LOST_W-1:0]     lost_cnt;
  logic [CNF_W-1:0]      cand_cnt;
  logic [CNF_W:0]        n_next;
  speed_t                cand, det_speed, cls, eff_speed;
  logic                  edge_full, ref_full, win_end;

  assign edge_full = &edge_cnt;
  assign ref_full  = &ref_cnt;
  assign win_end   = edge_full | ref_full;

  // Edge-full takes priority over reference overflow when both coincide.
  always_comb begin
    cls = SPEED_10M;
    if (edge_full)
      cls = (ref_cnt >= REF_CNT_W'(THRESH_100M)) ? SPEED_100M : SPEED_1000M;
    n_next = (cls == cand) ? ({1'b0, cand_cnt} + (CNF_W+1)'(1)) : (CNF_W+1)'(1);
  end

`ifdef ETH_SPEED_FORCE_EN
  assign eff_speed = force_en ? speed_t'(force_speed) : det_speed;
`else
  assign eff_speed = det_speed;
`endif

  // Window counters and clock-loss tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d   <= 1'b0;
      ref_cnt  <= '0;
      edge_cnt <= '0;
      lost_cnt <= '0;
    end else begin
      sync_d <= sync_q;
      if (win_end) begin
        ref_cnt  <= '0;
        edge_cnt <= '0;
        if (edge_cnt != '0)
          lost_cnt <= '0;
        else if (lost_cnt != LOST_W'(LOSS_WINDOWS))
          lost_cnt <= lost_cnt + LOST_W'(1);
      end else begin
        ref_cnt  <= ref_cnt + REF_CNT_W'(1);
        edge_cnt <= edge_cnt + EDGE_CNT_W'(edge_det);
      end
    end
  end

  // Candidate tracking: a differing class must repeat CONFIRM times in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= SPEED_10M;
      cand_cnt  <= '0;
      det_speed <= speed_t'(RESET_SPEED);
    end else if (win_end) begin
      if (cls == det_speed) begin
        cand_cnt <= '0;
      end else begin
        cand <= cls;
        if (n_next >= (CNF_W+1)'(CONFIRM)) begin
          det_speed <= cls;
          cand_cnt  <= '0;
        end else begin
          cand_cnt <= n_next[CNF_W-1:0];
        end
      end
    end
  end

  speed_t               speed_q;
  logic                 mii_q, chg_q, lost_q;
  logic [REF_CNT_W-1:0] meas_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= speed_t'(RESET_SPEED);
      mii_q   <= mii_sel(speed_t'(RESET_SPEED));
      chg_q   <= 1'b0;
      lost_q  <= 1'b0;
      meas_q  <= '0;
    end else begin
      speed_q <= eff_speed;
      mii_q   <= mii_sel(eff_speed);
      chg_q   <= (eff_speed != speed_q);
      lost_q  <= (lost_cnt == LOST_W'(LOSS_WINDOWS));
      if (win_end) meas_q <= ref_cnt;
    end
  end

  assign stat.speed         = speed_q;
  assign stat.mii_select    = mii_q;
  assign stat.speed_change  = chg_q;
  assign stat.rx_clk_lost   = lost_q;
  assign stat.measure_count = meas_q;

endmodule

// File: tb/tb_eth_speed_detect.sv
// Bench for eth_speed_detect: CONFIRM=1 and CONFIRM=3 instances driven by a
// shared toggle source and checked against a window-level reference model.
module tb_eth_speed_detect;

  localparam int S = 3, RMAX = 127, EMAX = 3, TH = 32, LW = 4;
  localparam logic [11:0] RST_VEC = {2'b10, 3'b000, 7'd0};

  logic       clk = 1'b0, rst_n = 1'b0, rx_toggle = 1'b0;
  logic       force_en = 1'b0;
  logic [1:0] force_speed = 2'b00;

  int errors = 0, checks = 0;
  int tog_period = 0, tog_cnt = 0;

  eth_speed_detect_if #(.REF_CNT_W(7)) s1 ();
  eth_speed_detect_if #(.REF_CNT_W(7)) s3 ();

  eth_speed_detect #(.CONFIRM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_toggle(rx_toggle),
`ifdef ETH_SPEED_FORCE_EN
    .force_en(force_en), .force_speed(force_speed),
`endif
    .stat(s1)
  );

  eth_speed_detect #(.CONFIRM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .rx_toggle(rx_toggle),
`ifdef ETH_SPEED_FORCE_EN
    .force_en(1'b0), .force_speed(2'b00),
`endif
    .stat(s3)
  );

  initial forever #4 clk = ~clk;

  // rx_toggle source: flips every tog_period clk (0 = hold)
  initial forever begin
    @(posedge clk); #1;
    if (tog_period > 0) begin
      tog_cnt++;
      if (tog_cnt >= tog_period) begin rx_toggle = ~rx_toggle; tog_cnt = 0; end
    end
  end

  // ---------------- reference model ----------------
  int m_hist[S];
  int m_ref, m_edg, m_lost, e_lost, e_meas;
  int m_det[2], m_cand[2], m_cnt[2], e_spd[2], e_chg[2];
  int conf[2] = '{1, 3};

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_hist[i] = 0;
    m_ref = 0; m_edg = 0; m_lost = 0; e_lost = 0; e_meas = 0;
    for (int k = 0; k < 2; k++) begin
      m_det[k] = 2; m_cand[k] = 0; m_cnt[k] = 0; e_spd[k] = 2; e_chg[k] = 0;
    end
  endtask

  task automatic model_step();
    int e, c, n, nspd;
    e = m_hist[S-1] ^ m_hist[S-2];
    for (int i = S-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = int'(rx_toggle);
    for (int k = 0; k < 2; k++) begin
      nspd = (k == 0 && force_en) ? int'(force_speed) : m_det[k];
      e_chg[k] = (nspd != e_spd[k]) ? 1 : 0;
      e_spd[k] = nspd;
    end
    e_lost = (m_lost == LW) ? 1 : 0;
    if (m_edg == EMAX || m_ref == RMAX) begin
      c = (m_edg == EMAX) ? ((m_ref >= TH) ? 1 : 2) : 0;
      e_meas = m_ref;
      if (m_edg != 0) m_lost = 0;
      else if (m_lost < LW) m_lost++;
      for (int k = 0; k < 2; k++) begin
        if (c == m_det[k]) m_cnt[k] = 0;
        else begin
          n = (c == m_cand[k]) ? m_cnt[k] + 1 : 1;
          m_cand[k] = c;
          if (n >= conf[k]) begin m_det[k] = c; m_cnt[k] = 0; end
          else m_cnt[k] = n;
        end
      end
      m_ref = 0; m_edg = 0;
    end else begin
      m_ref++; m_edg += e;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  function automatic logic [11:0] dut_vec(int k);
    if (k == 0) return {s1.speed, s1.mii_select, s1.speed_change, s1.rx_clk_lost, s1.measure_count};
    return {s3.speed, s3.mii_select, s3.speed_change, s3.rx_clk_lost, s3.measure_count};
  endfunction

  function automatic logic [11:0] exp_vec(int k);
    return {2'(e_spd[k]), (e_spd[k] != 2), 1'(e_chg[k]), 1'(e_lost), 7'(e_meas)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== RST_VEC) begin
        errors++; $display("FAIL reset dut%0d got=%h want=%h", k, dut_vec(k), RST_VEC);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_1000m();
    tog_period = 4;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL 1000m_model dut%0d t=%0t got=%h want=%h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      checks++;
      if (s1.speed !== 2'b10 || s1.speed_change !== 1'b0 || s1.mii_select !== 1'b0) begin
        errors++; $display("FAIL 1000m_hold t=%0t speed=%b chg=%b mii=%b want 10/0/0", $time, s1.speed, s1.speed_change, s1.mii_select);
      end
    end
  endtask

  task automatic test_100m();
    int p1 = 0;
    tog_period = 20;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL 100m_model dut%0d t=%0t got=%h want=%h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      if (s1.speed_change === 1'b1) p1++;
    end
    checks++;
    if (p1 != 1) begin errors++; $display("FAIL 100m_pulses got=%0d want=1", p1); end
    checks++;
    if (s1.speed !== 2'b01 || s1.mii_select !== 1'b1) begin
      errors++; $display("FAIL 100m_speed got=%b/%b want 01/1", s1.speed, s1.mii_select);
    end
    checks++;
    if (s1.measure_count < 55 || s1.measure_count > 65) begin
      errors++; $display("FAIL 100m_meas got=%0d want 55..65", s1.measure_count);
    end
  endtask

  task automatic test_loss();
    tog_period = 0;
    for (int i = 0; i < 768; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL loss_model dut%0d t=%0t got=%h want=%h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (s1.speed !== 2'b00 || s1.rx_clk_lost !== 1'b1) begin
      errors++; $display("FAIL loss_state got speed=%b lost=%b want 00/1", s1.speed, s1.rx_clk_lost);
    end
    tog_period = 20;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL resume_model dut%0d t=%0t got=%h want=%h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (s1.speed !== 2'b01 || s1.rx_clk_lost !== 1'b0) begin
      errors++; $display("FAIL resume_state got speed=%b lost=%b want 01/0", s1.speed, s1.rx_clk_lost);
    end
  endtask

  task automatic test_confirm();
    int p1 = 0, p3 = 0;
    tog_period = 4;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL confirm_model dut%0d t=%0t got=%h want=%h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
    end
    checks++;
    if (s3.speed !== 2'b10) begin errors++; $display("FAIL confirm_1000m got=%b want=10", s3.speed); end
    // one long gap yields exactly one 100M-rate window
    tog_period = 40;
    for (int i = 0; i < 191; i++) begin
      @(negedge clk);
      if (i == 40) tog_period = 4;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL glitch_model dut%0d t=%0t got=%h want=%h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      if (s1.speed_change === 1'b1) p1++;
      if (s3.speed_change === 1'b1) p3++;
    end
    checks++;
    if (p3 != 0 || s3.speed !== 2'b10) begin
      errors++; $display("FAIL confirm_glitch got pulses=%0d speed=%b want 0/10", p3, s3.speed);
    end
    checks++;
    if (p1 != 2) begin errors++; $display("FAIL confirm1_glitch got pulses=%0d want=2", p1); end
    p3 = 0;
    tog_period = 20;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL confirm3_model dut%0d t=%0t got=%h want=%h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      if (s3.speed_change === 1'b1) p3++;
    end
    checks++;
    if (p3 != 1 || s3.speed !== 2'b01) begin
      errors++; $display("FAIL confirm_commit got pulses=%0d speed=%b want 1/01", p3, s3.speed);
    end
  endtask

`ifdef ETH_SPEED_FORCE_EN
  task automatic test_force();
    tog_period = 4;
    repeat (200) @(negedge clk);
    force_en = 1'b1; force_speed = 2'b00;
    @(negedge clk);
    checks++;
    if (s1.speed !== 2'b00 || s1.speed_change !== 1'b1 || s1.mii_select !== 1'b1) begin
      errors++; $display("FAIL force_on got=%b/%b/%b want 00/1/1", s1.speed, s1.speed_change, s1.mii_select);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if (s1.speed !== 2'b00 || s1.speed_change !== 1'b0) begin
        errors++; $display("FAIL force_hold t=%0t got=%b/%b want 00/0", $time, s1.speed, s1.speed_change);
      end
    end
    force_en = 1'b0;
    @(negedge clk);
    checks++;
    if (s1.speed !== 2'b10 || s1.speed_change !== 1'b1) begin
      errors++; $display("FAIL force_off got=%b/%b want 10/1", s1.speed, s1.speed_change);
    end
    @(negedge clk);
    checks++;
    if (s1.speed_change !== 1'b0) begin errors++; $display("FAIL force_off_pulse got=%b want=0", s1.speed_change); end
  endtask
`endif

  task automatic test_reset_mid();
    tog_period = 4;
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (dut_vec(k) !== RST_VEC) begin
        errors++; $display("FAIL reset_async dut%0d got=%h want=%h", k, dut_vec(k), RST_VEC);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dut_vec(k) !== exp_vec(k)) begin
          errors++; $display("FAIL post_reset_model dut%0d t=%0t got=%h want=%h", k, $time, dut_vec(k), exp_vec(k));
        end
      end
      if (i < 6) begin
        checks++;
        if (s1.measure_count !== 7'd0) begin
          errors++; $display("FAIL post_reset_meas cyc=%0d got=%0d want=0", i, s1.measure_count);
        end
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 10; p++) begin
      tog_period = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 45));
      len = $urandom_range(100, 500);
`ifdef ETH_SPEED_FORCE_EN
      force_en = 1'($urandom_range(0, 3) == 0);
      force_speed = 2'($urandom_range(0, 2));
`endif
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (dut_vec(k) !== exp_vec(k)) begin
            errors++; $display("FAIL random_model dut%0d per=%0d t=%0t got=%h want=%h", k, tog_period, $time, dut_vec(k), exp_vec(k));
          end
        end
      end
    end
    force_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_1000m();
    test_100m();
    test_loss();
    test_confirm();
`ifdef ETH_SPEED_FORCE_EN
    test_force();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
